// File: rtl/piso_serializer_m.sv
// LSB-first parallel-in/serial-out serializer with valid/ready load handshake.
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_serializer_m #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("piso_serializer_m: WIDTH must be >= 2");
    end
  endgenerate

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Outputs depend only on state and registers; load_valid only steers next state.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    ser_valid  = 1'b0;
    ser_out    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        ser_out   = sreg[0];
        if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
          state_nxt = PARITY;
`else
          done       = 1'b1;
          load_ready = 1'b1;
          state_nxt  = load_valid ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        ser_valid  = 1'b1;
        busy       = 1'b1;
        ser_out    = par;
        done       = 1'b1;
        load_ready = 1'b1;
        state_nxt  = load_valid ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    accept = load_valid & load_ready;
  end

  // Reset wins over a same-edge accept; a fresh accept overrides the shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
`ifdef PISO_PARITY_EN
      par  <= 1'b0;
`endif
    end else if (accept) begin
      sreg <= d;
      cnt  <= '0;
`ifdef PISO_PARITY_EN
      par  <= ^d;
`endif
    end else if (state == SHIFT) begin
      sreg <= sreg >> 1;
      if (cnt != LAST) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_serializer_m.sv
// Bench for piso_serializer_m: directed vector tables plus random traffic vs. a bit-queue model.
module tb_piso_serializer_m;
`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 8 + PAR;
  // packed observation order: {ser_out, ser_valid, busy, done, load_ready}
  localparam logic [4:0] IDLE_O = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] d = 8'h00;
  logic       load_ready, ser_out, ser_valid, busy, done;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    logic       r;
    logic       lv;
    logic [7:0] dd;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  piso_serializer_m #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .d(d), .load_valid(load_valid), .load_ready(load_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done)
  );

  function automatic logic fbit(logic [7:0] w, int j);
    return (j < 8) ? w[j] : ^w;
  endfunction

  function automatic logic [4:0] fexp(logic [7:0] w, int j);
    logic lst;
    lst = (j == NB - 1);
    return {fbit(w, j), 1'b1, 1'b1, lst, lst};
  endfunction

  function automatic vec_t mk(logic r, logic lv, logic [7:0] dd, logic [4:0] e);
    vec_t v;
    v.r = r; v.lv = lv; v.dd = dd; v.exp = e;
    return v;
  endfunction

  function automatic logic [4:0] outs();
    return {ser_out, ser_valid, busy, done, load_ready};
  endfunction

  task automatic chk(string nm, logic [4:0] act, logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (out,valid,busy,done,ready)", nm, act, exp);
    end
  endtask

  task automatic step(logic r, logic lv, logic [7:0] dd);
    rst = r; load_valid = lv; d = dd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_tbl(string nm);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].lv, tbl[i].dd);
      chk($sformatf("%s[%0d]", nm, i), outs(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  task automatic single_frame(string nm, logic [7:0] w);
    tbl.push_back(mk(1'b0, 1'b1, w, fexp(w, 0)));
    for (int j = 1; j < NB; j++) tbl.push_back(mk(1'b0, 1'b0, 8'h00, fexp(w, j)));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, IDLE_O));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, IDLE_O));
    run_tbl(nm);
  endtask

  logic [1:0] q[$];  // {bit, last-of-frame} still to be shifted out
  logic       r, lv, rdy;
  logic [7:0] dd;
  logic [4:0] e;

  initial begin
    @(negedge clk);
    step(1'b1, 1'b1, 8'h5A);
    chk("reset", outs(), IDLE_O);

    single_frame("a5", 8'hA5);
    single_frame("07", 8'h07);
    // explicit parity-bit values for the two reference words
    if (PAR == 1) begin
      chk("par_a5", {4'b0000, fbit(8'hA5, 8)}, 5'b00000);
      chk("par_07", {4'b0000, fbit(8'h07, 8)}, 5'b00001);
    end

    // back-to-back: 00 offered and held until it is taken at the final bit
    tbl.push_back(mk(1'b0, 1'b1, 8'hFF, fexp(8'hFF, 0)));
    for (int j = 1; j < NB; j++) tbl.push_back(mk(1'b0, 1'b1, 8'h00, fexp(8'hFF, j)));
    tbl.push_back(mk(1'b0, 1'b1, 8'h00, fexp(8'h00, 0)));
    for (int j = 1; j < NB; j++) tbl.push_back(mk(1'b0, 1'b0, 8'h00, fexp(8'h00, j)));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, IDLE_O));
    run_tbl("b2b");

    // offers while busy are ignored
    tbl.push_back(mk(1'b0, 1'b1, 8'hA5, fexp(8'hA5, 0)));
    for (int j = 1; j < NB; j++)
      tbl.push_back(mk(1'b0, (j >= 2 && j <= 6), 8'h3C, fexp(8'hA5, j)));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, IDLE_O));
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, IDLE_O));
    run_tbl("busy_rej");

    // reset during cycle 4 aborts the frame with no done
    tbl.push_back(mk(1'b0, 1'b1, 8'hA5, fexp(8'hA5, 0)));
    for (int j = 1; j < 4; j++) tbl.push_back(mk(1'b0, 1'b0, 8'h00, fexp(8'hA5, j)));
    tbl.push_back(mk(1'b1, 1'b0, 8'h00, IDLE_O));
    for (int j = 0; j < NB; j++) tbl.push_back(mk(1'b0, 1'b0, 8'h00, IDLE_O));
    run_tbl("mid_rst");

    // reset and accept on the same edge: nothing captured
    tbl.push_back(mk(1'b1, 1'b1, 8'h5A, IDLE_O));
    for (int j = 0; j < 3; j++) tbl.push_back(mk(1'b0, 1'b0, 8'h00, IDLE_O));
    run_tbl("rst_acc");

    // random traffic; model is a queue of pending frame bits
    q.delete();
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 39) == 0);
      lv  = 1'($urandom_range(0, 1));
      dd  = 8'($urandom);
      rdy = (q.size() <= 1);
      step(r, lv, dd);
      if (r) q.delete();
      else begin
        if (q.size() > 0) void'(q.pop_front());
        if (lv && rdy)
          for (int j = 0; j < NB; j++) q.push_back({fbit(dd, j), (j == NB - 1)});
      end
      e = (q.size() == 0) ? IDLE_O : {q[0][1], 1'b1, 1'b1, q[0][0], (q.size() == 1)};
      chk($sformatf("rand[%0d]", c), outs(), e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_serializer_m.md
PISO_SERIALIZER_M -- requirements
Module: piso_serializer_m

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data word width in bits; legal values are WIDTH >= 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-004 SHALL have port d, input, WIDTH bits: the parallel word to be serialized.
REQ-005 SHALL have port load_valid, input, 1 bit: the upstream asserts it while d holds a word to send.
REQ-006 SHALL have port load_ready, output, 1 bit: the block can accept a word on the current edge.
REQ-007 SHALL have port ser_out, output, 1 bit: the serial data bit.
REQ-008 SHALL have port ser_valid, output, 1 bit: ser_out carries a frame bit this cycle.
REQ-009 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 SHALL have port done, output, 1 bit: a one-cycle pulse coincident with the last bit of a frame.

Function
REQ-011 SHALL implement the states IDLE, SHIFT and, when parity is compiled in, PARITY.
REQ-012 SHALL accept a word when load_valid and load_ready are both 1 at a rising edge, capturing d into an internal shift register.
REQ-013 SHALL drive ser_valid=1 and ser_out=d[0] in the cycle after acceptance, sending the word LSB-first at one bit per cycle for WIDTH cycles.
REQ-014 SHALL use a bit counter of $clog2(WIDTH) bits that counts 0..WIDTH-1 with no wrap beyond WIDTH-1.
REQ-015 SHALL, in IDLE, drive ser_valid=0, ser_out=0, busy=0, done=0 and load_ready=1.
REQ-016 SHALL drive busy=1 in SHIFT and PARITY.
REQ-017 SHALL drive load_ready=0 in SHIFT and PARITY, except in the final bit cycle of the frame.
REQ-018 SHALL assert done for exactly one cycle, during the final bit of the frame (data bit WIDTH-1, or the parity bit when enabled).
REQ-019 SHALL drive load_ready=1 during the final bit cycle of the frame.
REQ-020 SHALL, when a word is accepted in the final bit cycle, present bit 0 of the new word in the next cycle with no idle gap.
REQ-021 SHALL, when no word is accepted in the final bit cycle, return to IDLE on the next cycle.
REQ-022 SHALL ignore load_valid whenever load_ready=0; d changes during a frame SHALL NOT affect bits already captured.
REQ-023 SHALL keep all outputs registered or decoded from state only, with no combinational path from load_valid or d to any output.

Reset
REQ-024 SHALL, when rst=1 at a rising edge, enter IDLE, clear the shift register and counter, and drive ser_out=0, ser_valid=0, busy=0, done=0, load_ready=1 from the next cycle.
REQ-025 SHALL, on a reset mid-frame, abort the frame, discard the remaining bits and not pulse done.
REQ-026 SHALL give reset priority over a simultaneous acceptance, so the offered word is not captured.

Configuration
REQ-027 SHALL provide the macro PISO_PARITY_EN to compile the parity feature in or out.
REQ-028 SHALL, when PISO_PARITY_EN is defined, enter PARITY after data bit WIDTH-1 and send one even-parity bit (XOR of the captured word), making the frame WIDTH+1 cycles.
REQ-029 SHALL, when PISO_PARITY_EN is undefined, contain no PARITY state or parity logic, making the frame WIDTH cycles.

Verification
REQ-030 SHALL verify single word, WIDTH=8, parity off: d=8'hA5 accepted at edge 0 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1..8, ser_valid=1 on cycles 1..8, done=1 only on cycle 8, IDLE on cycle 9.
REQ-031 SHALL verify parity on: d=8'hA5 -> parity bit 0 on cycle 9 with done on cycle 9; d=8'h07 -> parity bit 1.
REQ-032 SHALL verify back-to-back: 8'hFF then 8'h00 offered with load_valid held -> 8 ones then 8 zeros contiguous, ser_valid never drops, done on cycles 8 and 16.
REQ-033 SHALL verify busy rejection: load_valid=1 with d=8'h3C during cycles 2..6 of an 8'hA5 frame -> output bits unchanged, 8'h3C not sent.
REQ-034 SHALL verify mid-frame reset: rst=1 at cycle 4 of an 8'hA5 frame -> from cycle 5 ser_valid=0, busy=0, load_ready=1, and done never asserts.
REQ-035 SHALL verify reset/accept collision: rst=1 with load_valid=1 and d=8'h5A on the same edge -> block stays IDLE and no frame is sent.
